// File: rtl/pdm_pkg.sv
// Shared constants and arithmetic helpers for the PDM decimator.
// Used by pdm_window_acc and pdm_decimator (optional macro: PDM_DEC_DISCARD_FIRST_EN).
package pdm_pkg;

    localparam int unsigned PDM_WIN_LOG2_DEF = 6;
    localparam int unsigned PDM_OUT_W_DEF    = 5;

    // One extra bit so a full window of ones (2^win_log2) fits.
    function automatic int unsigned pdm_acc_width(input int unsigned win_log2);
        return win_log2 + 1;
    endfunction

    function automatic int unsigned pdm_sat_scale(input int unsigned count,
                                                  input int unsigned shift,
                                                  input int unsigned out_w);
        int unsigned scaled;
        int unsigned max_val;
        scaled  = count >> shift;
        max_val = (32'd1 << out_w) - 32'd1;
        return (scaled > max_val) ? max_val : scaled;
    endfunction

endpackage

// File: rtl/pdm_window_acc.sv
// Window counter and ones accumulator for the PDM decimator.
// Emits a one-cycle win_done with the final count (including the closing sample).
module pdm_window_acc
    import pdm_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = PDM_WIN_LOG2_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pdm_in,
    input  logic              en,
    input  logic              sync,
    output logic              win_done,
    output logic [WIN_LOG2:0] count
);

    localparam int unsigned AW = pdm_acc_width(WIN_LOG2);

    logic [WIN_LOG2-1:0] cnt;
    logic [AW-1:0]       acc;
    logic                last;

    assign last     = (cnt == {WIN_LOG2{1'b1}});
    assign win_done = en && !sync && last;
    assign count    = acc + AW'(pdm_in);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            acc <= '0;
        end else if (sync) begin
            cnt <= '0;
            acc <= '0;
        end else if (en) begin
            if (last) begin
                // Next window starts on the following cycle with no gap.
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + WIN_LOG2'(1);
                acc <= acc + AW'(pdm_in);
            end
        end
    end

endmodule

// File: rtl/pdm_decimator.sv
// PDM-to-PCM decimator: windowed ones count, saturating scale, valid/ready output register.
// Optional macro PDM_DEC_DISCARD_FIRST_EN drops the first window after reset or sync.
module pdm_decimator
    import pdm_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = PDM_WIN_LOG2_DEF,
    parameter int unsigned OUT_W    = PDM_OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pdm_in,
    input  logic             en,
    input  logic             sync,
    output logic [OUT_W-1:0] pcm_data,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             overrun
);

    localparam int unsigned SHIFT = WIN_LOG2 - OUT_W;

    logic              win_done;
    logic [WIN_LOG2:0] win_count;
    logic [OUT_W-1:0]  result;
    logic              take;

    pdm_window_acc #(
        .WIN_LOG2(WIN_LOG2)
    ) u_window_acc (
        .clk     (clk),
        .reset   (reset),
        .pdm_in  (pdm_in),
        .en      (en),
        .sync    (sync),
        .win_done(win_done),
        .count   (win_count)
    );

    always_comb begin
        result = OUT_W'(pdm_sat_scale(32'(win_count), SHIFT, OUT_W));
    end

`ifdef PDM_DEC_DISCARD_FIRST_EN
    logic primed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            primed <= 1'b0;
        end else if (sync) begin
            primed <= 1'b0;
        end else if (win_done) begin
            primed <= 1'b1;
        end
    end

    // The settling window neither loads nor counts toward overrun.
    assign take = win_done && primed;
`else
    assign take = win_done;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (sync) begin
                overrun <= 1'b0;
            end
            if (take) begin
                if (!pcm_valid || pcm_ready) begin
                    pcm_data  <= result;
                    pcm_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pcm_valid && pcm_ready) begin
                pcm_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator: directed scenarios plus randomized traffic
// against a window-of-samples reference model (honours PDM_DEC_DISCARD_FIRST_EN).
module tb_pdm_decimator;

    localparam int WIN   = 64;
    localparam int SHIFT = 1;
    localparam int MAXV  = 31;
`ifdef PDM_DEC_DISCARD_FIRST_EN
    localparam int FIRST_LAT = 2 * WIN;
`else
    localparam int FIRST_LAT = WIN;
`endif

    logic       clk;
    logic       reset;
    logic       pdm_in;
    logic       en;
    logic       sync;
    logic [4:0] pcm_data;
    logic       pcm_valid;
    logic       pcm_ready;
    logic       overrun;

    int n_checks;
    int n_pass;

    // Reference model state.
    int         win_q[$];
    logic       m_valid;
    logic [4:0] m_data;
    logic       m_ovr;
    logic       m_primed;

    pdm_decimator #(
        .WIN_LOG2(6),
        .OUT_W   (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pdm_in   (pdm_in),
        .en       (en),
        .sync     (sync),
        .pcm_data (pcm_data),
        .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        win_q.delete();
        m_valid  = 1'b0;
        m_data   = '0;
        m_ovr    = 1'b0;
        m_primed = 1'b0;
    endtask

    task automatic model_update(input logic p, input logic e, input logic s, input logic r);
        logic have_res;
        int   ones;
        int   res;
        have_res = 1'b0;
        res      = 0;
        if (s) begin
            win_q.delete();
            m_ovr    = 1'b0;
            m_primed = 1'b0;
        end else if (e) begin
            win_q.push_back(int'(p));
            if (win_q.size() == WIN) begin
                ones = 0;
                foreach (win_q[k]) ones += win_q[k];
                res = ones / (1 << SHIFT);
                if (res > MAXV) res = MAXV;
                win_q.delete();
`ifdef PDM_DEC_DISCARD_FIRST_EN
                have_res = m_primed;
`else
                have_res = 1'b1;
`endif
                m_primed = 1'b1;
            end
        end
        if (have_res) begin
            if (!m_valid || r) begin
                m_data  = 5'(res);
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    // Drive one clock's inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic p, input logic e, input logic s, input logic r);
        pdm_in    = p;
        en        = e;
        sync      = s;
        pcm_ready = r;
        model_update(p, e, s, r);
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
`ifdef PDM_DEC_DISCARD_FIRST_EN
        for (int i = 0; i < WIN; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pdm_in = 1'b0; en = 1'b0; sync = 1'b0; pcm_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (pcm_valid !== 1'b0 || pcm_data !== 5'd0 || overrun !== 1'b0)
            $display("FAIL reset_outputs: valid=%b data=%0d ovr=%b, want 0/0/0",
                     pcm_valid, pcm_data, overrun);
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_constant_ones();
        int lat;
        lat = 0;
        while (pcm_valid !== 1'b1 && lat < 300) begin step(1'b1, 1'b1, 1'b0, 1'b1); lat++; end
        n_checks++;
        if (lat !== FIRST_LAT) $display("FAIL ones_first_latency: got %0d want %0d", lat, FIRST_LAT);
        else n_pass++;
        n_checks++;
        if (pcm_data !== 5'd31) $display("FAIL ones_saturated: got %0d want 31", pcm_data);
        else n_pass++;
        lat = 0;
        step(1'b1, 1'b1, 1'b0, 1'b1); lat++;
        n_checks++;
        if (pcm_valid !== 1'b0) $display("FAIL ones_consumed: valid=%b want 0", pcm_valid);
        else n_pass++;
        while (pcm_valid !== 1'b1 && lat < 300) begin step(1'b1, 1'b1, 1'b0, 1'b1); lat++; end
        n_checks++;
        if (lat !== WIN || pcm_data !== 5'd31)
            $display("FAIL ones_repeat: period %0d data %0d, want %0d and 31", lat, pcm_data, WIN);
        else n_pass++;
    endtask

    task automatic test_density();
        step(1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        for (int i = 0; i < WIN; i++) step(1'(i % 2 == 0), 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (pcm_valid !== 1'b1 || pcm_data !== 5'd16)
            $display("FAIL alternating: valid=%b data=%0d, want 1/16", pcm_valid, pcm_data);
        else n_pass++;
        for (int i = 0; i < WIN; i++) step(1'(i < 17), 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (pcm_valid !== 1'b1 || pcm_data !== 5'd8)
            $display("FAIL ones17: valid=%b data=%0d, want 1/8", pcm_valid, pcm_data);
        else n_pass++;
    endtask

    task automatic test_overrun();
        step(1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        for (int i = 0; i < WIN; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (pcm_valid !== 1'b1 || pcm_data !== 5'd31 || overrun !== 1'b0)
            $display("FAIL overrun_first: valid=%b data=%0d ovr=%b, want 1/31/0",
                     pcm_valid, pcm_data, overrun);
        else n_pass++;
        for (int i = 0; i < WIN; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (pcm_valid !== 1'b1 || pcm_data !== 5'd31 || overrun !== 1'b1)
            $display("FAIL overrun_second: valid=%b data=%0d ovr=%b, want 1/31/1",
                     pcm_valid, pcm_data, overrun);
        else n_pass++;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (pcm_valid !== 1'b1 || pcm_data !== 5'd31 || overrun !== 1'b0)
            $display("FAIL overrun_sync_clear: valid=%b data=%0d ovr=%b, want 1/31/0",
                     pcm_valid, pcm_data, overrun);
        else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (pcm_valid !== 1'b0) $display("FAIL overrun_drain: valid=%b want 0", pcm_valid);
        else n_pass++;
    endtask

    task automatic test_enable();
        int lat;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        lat = 0;
        while (pcm_valid !== 1'b1 && lat < 400) begin
            step(1'b1, 1'(lat % 2 == 1), 1'b0, 1'b1);
            lat++;
        end
        n_checks++;
        if (lat !== 2 * WIN || pcm_data !== 5'd31)
            $display("FAIL en_toggle: latency %0d data %0d, want %0d and 31", lat, pcm_data, 2 * WIN);
        else n_pass++;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        lat = 0;
        while (pcm_valid !== 1'b1 && lat < 400) begin
            step(1'b1, 1'(lat < 20 || lat >= 30), 1'b0, 1'b1);
            lat++;
        end
        n_checks++;
        if (lat !== WIN + 10) $display("FAIL en_pause: latency %0d want %0d", lat, WIN + 10);
        else n_pass++;
    endtask

    task automatic test_sync_mid();
        int lat;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        lat = 0;
        while (pcm_valid !== 1'b1 && lat < 400) begin step(1'b1, 1'b1, 1'b0, 1'b1); lat++; end
        n_checks++;
        if (lat !== FIRST_LAT) $display("FAIL sync_mid_latency: got %0d want %0d", lat, FIRST_LAT);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        for (int i = 0; i < WIN + 30; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (pcm_valid !== 1'b1) $display("FAIL reset_mid_pre: valid=%b want 1", pcm_valid);
        else n_pass++;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (pcm_valid !== 1'b0 || pcm_data !== 5'd0 || overrun !== 1'b0)
            $display("FAIL reset_mid_async: valid=%b data=%0d ovr=%b, want 0/0/0",
                     pcm_valid, pcm_data, overrun);
        else n_pass++;
        #1;
        reset = 1'b1;
        lat = 0;
        while (pcm_valid !== 1'b1 && lat < 400) begin step(1'b1, 1'b1, 1'b0, 1'b1); lat++; end
        n_checks++;
        if (lat !== FIRST_LAT || pcm_data !== 5'd31)
            $display("FAIL reset_mid_restart: latency %0d data %0d, want %0d and 31",
                     lat, pcm_data, FIRST_LAT);
        else n_pass++;
    endtask

    task automatic test_random();
        int density;
        int ready_bias;
        density    = 32;
        ready_bias = 2;
        for (int i = 0; i < 4000; i++) begin
            if (i % WIN == 0) begin
                density    = int'($urandom_range(0, WIN));
                ready_bias = int'($urandom_range(0, 4));
            end
            step(1'(int'($urandom_range(0, WIN - 1)) < density),
                 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 299) == 0),
                 1'(int'($urandom_range(0, 3)) < ready_bias));
            n_checks++;
            if (pcm_valid !== m_valid || pcm_data !== m_data || overrun !== m_ovr)
                $display("FAIL random_cycle_%0d: valid=%b data=%0d ovr=%b, want %b/%0d/%b",
                         i, pcm_valid, pcm_data, overrun, m_valid, m_data, m_ovr);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_constant_ones();
        test_density();
        test_overrun();
        test_enable();
        test_sync_mid();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pdm_decimator.md
Name: pdm_decimator

Overview:
- Downstream stage of the 5-bit PDM generator: consumes its 1-bit pulse-density stream and recovers a PCM level.
- Counts ones over a fixed window of 2^WIN_LOG2 enabled cycles and scales the count to OUT_W bits.
- Delivers each result through a single-entry valid/ready output register with a sticky overrun flag.
- Sits between the PDM generator output pin and any capture/readback logic on the tile.

Parameters:
- WIN_LOG2, 6: window length is 2^WIN_LOG2 enabled cycles (64).
- OUT_W, 5: result width; must satisfy 1 <= OUT_W <= WIN_LOG2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- pdm_in  input  1  PDM bitstream sample.
- en  input  1  sample qualifier; the cycle counts only when en=1.
- sync  input  1  window restart strobe.
- pcm_data  output  OUT_W  recovered level, stable while pcm_valid=1.
- pcm_valid  output  1  output register holds an unconsumed result.
- pcm_ready  input  1  consumer accepts pcm_data when pcm_valid and pcm_ready are both 1.
- overrun  output  1  sticky: a result was dropped because the output register was full.

Behaviour:
- Reset (reset=0, asynchronous) clears all state:
  - pcm_data=0, pcm_valid=0, overrun=0.
  - Window counter (WIN_LOG2 bits) = 0; ones accumulator (WIN_LOG2+1 bits) = 0.
- Accumulate: on a cycle with en=1 and sync=0:
  - accumulator += pdm_in; window counter += 1, wrapping mod 2^WIN_LOG2.
- Window end: the enabled cycle where the window counter equals 2^WIN_LOG2-1.
  - Result = (accumulator + pdm_in) >> (WIN_LOG2-OUT_W), saturated to 2^OUT_W-1. An all-ones window yields all-ones, never 0.
  - Accumulator and counter reset to 0 on the same edge; the next window starts immediately with no gap cycle.
- Latency: pcm_valid rises on the edge that closes the window, so it is visible the cycle after the last sample.
- Output register:
  - Empty + result: load pcm_data, set pcm_valid.
  - Full + pcm_ready=1 on the result cycle: the old result is consumed and the new one loads; pcm_valid stays 1.
  - Full + pcm_ready=0 on the result cycle: the new result is dropped, the old one is kept, and overrun is set.
  - pcm_ready=1 with no new result: pcm_valid clears.
  - pcm_ready is ignored while pcm_valid=0.
- en=0 freezes the counter and accumulator; the handshake still operates.
- sync=1 takes priority over en:
  - Clears the counter and accumulator; that cycle's sample is discarded.
  - Clears overrun.
  - Leaves pcm_data and pcm_valid untouched.
  - sync on a would-be window-end cycle produces no result.
- Reset asserted mid-window or mid-handshake discards everything immediately. There is no partial result.

Optional Feature:
- Macro: PDM_DEC_DISCARD_FIRST_EN.
- Defined: the first completed window after reset or sync is a settling window. Its result is neither loaded nor counted toward overrun. An internal "primed" flag clears on reset/sync and sets at that window's end.
- Undefined: every completed window produces a result.

Decomposition:
- Package pdm_pkg:
  - PDM_WIN_LOG2_DEF=6, PDM_OUT_W_DEF=5.
  - Function returning the accumulator width (WIN_LOG2+1).
  - Saturating scale function (count, shift) -> OUT_W.
- Sub-module pdm_window_acc: counter + accumulator + sync/en handling. Outputs a one-cycle win_done pulse and the final count.
- Top level: scaling, saturation, output register / handshake, overrun, optional primed flag.

Test Plan:
- Constant pdm_in=1, en=1, pcm_ready=1 after reset → first pcm_valid on cycle 64 after release, pcm_data=31 (saturated); repeats every 64 cycles.
- Alternating 1/0 stream → pcm_data=16; stream with exactly 17 ones per 64 cycles → pcm_data=8.
- pcm_ready held 0 across two windows → first result kept, overrun=1 after second window end; pulse sync → overrun=0, pcm_valid still 1.
- en toggling every other cycle with constant 1 → result after 128 clocks, value 31; en=0 for 10 cycles mid-window delays pcm_valid by exactly 10 cycles.
- sync pulsed at enabled-cycle 40 → no result at cycle 64; next result 64 enabled cycles after sync; with PDM_DEC_DISCARD_FIRST_EN the first result appears 128 cycles after sync.
- reset pulled low at enabled-cycle 30 with pcm_valid=1 → all outputs 0 asynchronously; the next window counts from 0 after release.
